// File: rtl/bin_to_bcd4.sv
// Serial binary-to-BCD converter for a four-digit display (value in units of 0.1).
// Double-dabble over 14 SHIFT cycles; digits update atomically when the result is ready.
module bin_to_bcd4 #(
  parameter bit CLAMP = 1'b1  // 1: out-of-range shows 9999, 0: digits keep their previous value
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] value,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [3:0]  tenth,
  output logic [3:0]  ones,
  output logic [3:0]  tens,
  output logic [3:0]  hundred
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [13:0] MAX_VALUE  = 14'd9999;
  localparam logic [3:0]  ITERATIONS = 4'd14;

  state_t      state;
  logic [13:0] bin_sr;    // binary operand, consumed MSB-first
  logic [15:0] scratch;   // BCD accumulator, never visible on the outputs
  logic [3:0]  count;     // SHIFT iterations remaining
  logic        ovf;       // accepted value was out of range

  logic [15:0] adjusted;
  logic [29:0] shifted;

  // Add 3 to a BCD nibble of 5 or more so the following shift carries into the next digit.
  function automatic logic [3:0] dabble(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

  // One double-dabble step: correct every nibble, then shift {scratch, binary} left by one.
  always_comb begin
    // NOTE: every signal assigned here gets a value on every pass, so no latch is inferred.
    adjusted = {dabble(scratch[15:12]), dabble(scratch[11:8]),
                dabble(scratch[7:4]),   dabble(scratch[3:0])};
    shifted  = {adjusted, bin_sr} << 1;
  end

  // Conversion FSM with registered status outputs and display digits.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      bin_sr   <= '0;
      scratch  <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      hundred  <= '0;
      tens     <= '0;
      ones     <= '0;
      tenth    <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (value > MAX_VALUE) begin
              bin_sr <= MAX_VALUE;
              ovf    <= 1'b1;
            end else begin
              bin_sr <= value;
              ovf    <= 1'b0;
            end
            scratch <= '0;
            count   <= ITERATIONS;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end

        SHIFT: begin
          scratch <= shifted[29:14];
          bin_sr  <= shifted[13:0];
          count   <= count - 4'd1;
          if (count == 4'd1) begin
            // Last step: publish the finished result together with the done pulse.
            state    <= DONE;
            done     <= 1'b1;
            overflow <= ovf;
            if (CLAMP || !ovf) begin
              hundred <= shifted[29:26];
              tens    <= shifted[25:22];
              ones    <= shifted[21:18];
              tenth   <= shifted[17:14];
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd4.sv
// Directed bench for bin_to_bcd4: one clamping and one non-clamping instance share stimulus.
module tb_bin_to_bcd4;

  logic        clk_100MHz;
  logic        reset;
  logic        start;
  logic [13:0] value;

  logic        busy_c, done_c, overflow_c;
  logic [3:0]  tenth_c, ones_c, tens_c, hundred_c;
  logic        busy_k, done_k, overflow_k;
  logic [3:0]  tenth_k, ones_k, tens_k, hundred_k;

  logic [15:0] dig_c, dig_k;
  assign dig_c = {hundred_c, tens_c, ones_c, tenth_c};
  assign dig_k = {hundred_k, tens_k, ones_k, tenth_k};

  int tests_run;
  int tests_failed;

  bin_to_bcd4 #(.CLAMP(1'b1)) u_dut (
    .clk_100MHz(clk_100MHz), .reset(reset), .start(start), .value(value),
    .busy(busy_c), .done(done_c), .overflow(overflow_c),
    .tenth(tenth_c), .ones(ones_c), .tens(tens_c), .hundred(hundred_c)
  );

  bin_to_bcd4 #(.CLAMP(1'b0)) u_dut_keep (
    .clk_100MHz(clk_100MHz), .reset(reset), .start(start), .value(value),
    .busy(busy_k), .done(done_k), .overflow(overflow_k),
    .tenth(tenth_k), .ones(ones_k), .tens(tens_k), .hundred(hundred_k)
  );

  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  // Pulse start for one edge, then observe cycles 1..17 (cycle n = period after accept edge + n-1).
  task automatic convert(input logic [13:0] v, output int d_cycle, output int d_cnt,
                         output int k_cycle, output int busy_bad);
    @(negedge clk_100MHz);
    start = 1'b1;
    value = v;
    @(posedge clk_100MHz);
    @(negedge clk_100MHz);
    start = 1'b0;
    d_cycle = -1; d_cnt = 0; k_cycle = -1; busy_bad = 0;
    for (int c = 1; c <= 17; c++) begin
      if (c > 1) @(negedge clk_100MHz);
      if (done_c) begin
        d_cnt++;
        if (d_cycle < 0) d_cycle = c;
      end
      if (done_k && k_cycle < 0) k_cycle = c;
      if (busy_c !== (c <= 15)) busy_bad++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; value = '0;
    #12;
    tests_run++;
    if (busy_c !== 1'b0 || done_c !== 1'b0 || overflow_c !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: busy=%b done=%b overflow=%b, required 0 0 0", busy_c, done_c, overflow_c);
    end
    tests_run++;
    if (dig_c !== 16'h0000 || dig_k !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_digits: clamp=%h keep=%h, required 0000", dig_c, dig_k);
    end
    @(negedge clk_100MHz);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int dc, dn, kc, bb;
    convert(14'd1234, dc, dn, kc, bb);
    tests_run++;
    if (dc !== 15 || dn !== 1) begin
      tests_failed++;
      $display("FAIL basic_latency: done cycle=%0d pulses=%0d, required 15 1", dc, dn);
    end
    tests_run++;
    if (bb !== 0) begin
      tests_failed++;
      $display("FAIL basic_busy: %0d busy errors over cycles 1..17, required 0", bb);
    end
    tests_run++;
    if (dig_c !== 16'h1234 || overflow_c !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_1234: digits=%h overflow=%b, required 1234 0", dig_c, overflow_c);
    end
    tests_run++;
    if (dig_k !== 16'h1234) begin
      tests_failed++;
      $display("FAIL basic_keep: digits=%h, required 1234", dig_k);
    end
  endtask

  task automatic test_zero_max();
    int dc, dn, kc, bb;
    convert(14'd0, dc, dn, kc, bb);
    tests_run++;
    if (dig_c !== 16'h0000 || overflow_c !== 1'b0 || dc !== 15) begin
      tests_failed++;
      $display("FAIL zero: digits=%h overflow=%b cycle=%0d, required 0000 0 15", dig_c, overflow_c, dc);
    end
    convert(14'd9999, dc, dn, kc, bb);
    tests_run++;
    if (dig_c !== 16'h9999 || overflow_c !== 1'b0 || dc !== 15) begin
      tests_failed++;
      $display("FAIL max: digits=%h overflow=%b cycle=%0d, required 9999 0 15", dig_c, overflow_c, dc);
    end
    tests_run++;
    if (dig_k !== 16'h9999 || overflow_k !== 1'b0) begin
      tests_failed++;
      $display("FAIL max_keep: digits=%h overflow=%b, required 9999 0", dig_k, overflow_k);
    end
  endtask

  task automatic test_ignore_start();
    int d_cycle, d_cnt;
    @(negedge clk_100MHz);
    start = 1'b1;
    value = 14'd1234;
    @(posedge clk_100MHz);
    @(negedge clk_100MHz);
    start = 1'b0;
    d_cycle = -1; d_cnt = 0;
    for (int c = 1; c <= 22; c++) begin
      if (c > 1) @(negedge clk_100MHz);
      if (done_c) begin
        d_cnt++;
        if (d_cycle < 0) d_cycle = c;
      end
      if (c == 5) begin
        start = 1'b1;
        value = 14'd5678;
      end
      if (c == 6) start = 1'b0;
    end
    tests_run++;
    if (d_cnt !== 1 || d_cycle !== 15) begin
      tests_failed++;
      $display("FAIL ignore_pulses: pulses=%0d first=%0d, required 1 15", d_cnt, d_cycle);
    end
    tests_run++;
    if (dig_c !== 16'h1234 || busy_c !== 1'b0) begin
      tests_failed++;
      $display("FAIL ignore_result: digits=%h busy=%b, required 1234 0", dig_c, busy_c);
    end
  endtask

  task automatic test_overflow();
    int dc, dn, kc, bb;
    convert(14'd12000, dc, dn, kc, bb);
    tests_run++;
    if (dig_c !== 16'h9999 || overflow_c !== 1'b1 || dc !== 15) begin
      tests_failed++;
      $display("FAIL ovf_clamp: digits=%h overflow=%b cycle=%0d, required 9999 1 15", dig_c, overflow_c, dc);
    end
    tests_run++;
    if (dig_k !== 16'h1234 || overflow_k !== 1'b1 || kc !== 15) begin
      tests_failed++;
      $display("FAIL ovf_keep: digits=%h overflow=%b cycle=%0d, required 1234 1 15", dig_k, overflow_k, kc);
    end
  endtask

  task automatic test_abort_reset();
    int dn, dc, d_cnt, kc, bb;
    @(negedge clk_100MHz);
    start = 1'b1;
    value = 14'd5678;
    @(posedge clk_100MHz);
    @(negedge clk_100MHz);
    start = 1'b0;
    for (int c = 2; c <= 7; c++) @(negedge clk_100MHz);
    reset = 1'b1;
    #1;
    tests_run++;
    if (busy_c !== 1'b0 || done_c !== 1'b0 || overflow_c !== 1'b0 || dig_c !== 16'h0000 || dig_k !== 16'h0000) begin
      tests_failed++;
      $display("FAIL abort_now: busy=%b done=%b ovf=%b digits=%h/%h, required 0 0 0 0000/0000",
               busy_c, done_c, overflow_c, dig_c, dig_k);
    end
    @(negedge clk_100MHz);
    reset = 1'b0;
    d_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_100MHz);
      if (done_c || busy_c) d_cnt++;
    end
    tests_run++;
    if (d_cnt !== 0) begin
      tests_failed++;
      $display("FAIL abort_quiet: %0d cycles with done/busy after abort, required 0", d_cnt);
    end
    convert(14'd42, dc, dn, kc, bb);
    tests_run++;
    if (dig_c !== 16'h0042 || dc !== 15 || dn !== 1) begin
      tests_failed++;
      $display("FAIL abort_restart: digits=%h cycle=%0d pulses=%0d, required 0042 15 1", dig_c, dc, dn);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int bad_dig;
    n = 0; bad_dig = 0;
    @(negedge clk_100MHz);
    start = 1'b1;
    value = 14'd100;
    @(posedge clk_100MHz);
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk_100MHz);
      if (done_c) begin
        tests_run++;
        if (c !== 15 + 16 * n) begin
          tests_failed++;
          $display("FAIL b2b_period: pulse %0d at cycle %0d, required %0d", n, c, 15 + 16 * n);
        end
        if (dig_c !== 16'h0100) bad_dig++;
        n++;
      end
    end
    start = 1'b0;
    tests_run++;
    if (n !== 4 || bad_dig !== 0) begin
      tests_failed++;
      $display("FAIL b2b_count: pulses=%0d bad digits=%0d, required 4 0", n, bad_dig);
    end
    for (int c = 0; c < 20; c++) @(negedge clk_100MHz);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_basic();
    test_zero_max();
    test_ignore_start();
    test_overflow();
    test_abort_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
